// File: rtl/rr_arbiter_4_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4_pkg
// Shared definitions for the four-requester round-robin arbiter: requester
// count, index type and the FSM state encoding.
// -----------------------------------------------------------------------------
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage : rr_arbiter_4_pkg

// File: rtl/rr_arbiter_4_if.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4_if
// Request/grant bundle between the four clients and the arbiter.
//   req       : client -> arbiter, one request line per client
//   grant     : arbiter -> clients, one-hot grant (all zero when idle)
//   grant_idx : arbiter -> clients, index of current or last granted client
//   busy      : arbiter -> clients, high while a grant is active
//   timeout   : arbiter -> clients, one-cycle pulse after a forced hand-off
// Modports: master = the arbiter, slave = the client side.
// -----------------------------------------------------------------------------
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  idx_t             grant_idx;
  logic             busy;
  logic             timeout;

  modport master (
    input  req,
    output grant,
    output grant_idx,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  grant_idx,
    input  busy,
    input  timeout
  );

endinterface : rr_arbiter_4_if

// File: rtl/rr_arbiter_4_decoder_2x4.sv
// -----------------------------------------------------------------------------
// decoder_2x4
// Two-to-four one-hot decoder with active-high enable.
//   in     : 2-bit select
//   enable : when low, out is all zero
//   out    : one-hot decode of in
// -----------------------------------------------------------------------------
module decoder_2x4 (
  input  logic [1:0] in,
  input  logic       enable,
  output logic [3:0] out
);

  // NOTE: assign a default before the case so no path leaves out unassigned;
  // otherwise synthesis infers a latch.
  always_comb begin
    out = 4'b0000;
    if (enable) begin
      case (in)
        2'd0: out = 4'b0001;
        2'd1: out = 4'b0010;
        2'd2: out = 4'b0100;
        2'd3: out = 4'b1000;
        default: out = 4'b0000;
      endcase
    end
  end

endmodule : decoder_2x4

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
// Four-requester round-robin arbiter. A client keeps the grant until it drops
// its request or, when MAX_HOLD is non-zero, until it has held the resource
// for MAX_HOLD consecutive cycles. Hand-offs happen in a single edge with no
// idle bubble. The grant vector is decoded from registered state only.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_arbiter_4_if.master (req in; grant, grant_idx, busy, timeout out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per tenure, 0 disables the limit
//   HOLD_W   : width of the hold counter, MAX_HOLD must be < 2**HOLD_W
// -----------------------------------------------------------------------------
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter_4_if.master  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_e            state;
  idx_t              cur_idx;
  idx_t              last_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  idx_t              search_start;
  logic [2:0]        pick;
  logic              found;
  idx_t              winner;
  logic              cur_release;
  logic              cur_expire;

  // Scan r from start upward, mod 4. Walking the offsets from the far end
  // down lets the nearest set bit overwrite any farther one.
  function automatic logic [2:0] find_winner(input logic [N_REQ-1:0] r,
                                             input idx_t             start);
    logic [2:0] res;
    idx_t       idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + idx_t'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT the search always starts just past the current holder, so on an
  // expiry the holder is considered last and is re-granted only if alone.
  assign search_start = (state == ST_GRANT) ? cur_idx + 2'd1 : last_idx + 2'd1;
  assign pick         = find_winner(bus.req, search_start);
  assign found        = pick[2];
  assign winner       = pick[1:0];

  assign cur_release  = ~bus.req[cur_idx];
  assign cur_expire   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) &&
                        bus.req[cur_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      last_idx  <= 2'd3;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_GRANT;
            cur_idx  <= winner;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (cur_release || cur_expire) begin
            last_idx  <= cur_idx;
            // cur_expire already implies the holder still requests, so a
            // simultaneous release never produces a pulse.
            timeout_q <= cur_expire;
            hold_cnt  <= '0;
            if (found) begin
              cur_idx <= winner;
            end else begin
              state   <= ST_IDLE;
            end
          end else if (hold_cnt != '1) begin
            // Saturate so an unlimited tenure (MAX_HOLD == 0) cannot wrap.
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
      endcase
    end
  end

  decoder_2x4 u_decoder (
    .in     (cur_idx),
    .enable (bus.busy),
    .out    (bus.grant)
  );

  assign bus.busy      = (state == ST_GRANT);
  assign bus.grant_idx = cur_idx;
  assign bus.timeout   = timeout_q;

endmodule : rr_arbiter_4

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4
// Self-checking bench for rr_arbiter_4 with MAX_HOLD=4. Each scenario task
// pushes the expected {grant, grant_idx, busy, timeout} for the coming edge
// onto a scoreboard queue as it drives req/rst, then pops and compares 1 ns
// after that edge.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;
  import rr_arbiter_4_pkg::*;

  localparam int MAX_HOLD = 4;

  typedef struct {
    string      name;
    logic [7:0] v;   // {grant[3:0], grant_idx[1:0], busy, timeout}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic string fmt(input logic [7:0] v);
    return $sformatf("grant=%b idx=%0d busy=%b timeout=%b",
                     v[7:4], v[3:2], v[1], v[0]);
  endfunction

  function automatic logic [7:0] observed();
    return {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
  endfunction

  task automatic push_exp(input string name, input logic [3:0] g,
                          input logic [1:0] i, input logic b, input logic t);
    exp_t e;
    e.name = name;
    e.v    = {g, i, b, t};
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t       e;
    logic [7:0] obs;
    // Requests are high during reset and must be ignored.
    for (int c = 0; c < 2; c++) begin
      rst     = 1'b1;
      bus.req = 4'b1111;
      push_exp($sformatf("reset_c%0d", c), 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] reqs [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [7:0] want [5] = '{{4'b0100, 2'd2, 1'b1, 1'b0},
                             {4'b0100, 2'd2, 1'b1, 1'b0},
                             {4'b0100, 2'd2, 1'b1, 1'b0},
                             {4'b0000, 2'd2, 1'b0, 1'b0},
                             {4'b0000, 2'd2, 1'b0, 1'b0}};
    exp_t       e;
    logic [7:0] obs;
    for (int c = 0; c < 5; c++) begin
      bus.req = reqs[c];
      push_exp($sformatf("single_c%0d", c), want[c][7:4], want[c][3:2],
               want[c][1], want[c][0]);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
  endtask

  task automatic test_fairness();
    exp_t       e;
    logic [7:0] obs;
    int         who;
    apply_reset();
    // All four request continuously: each tenure is exactly MAX_HOLD cycles,
    // the pulse marks the first cycle of every forced successor.
    for (int c = 0; c < 5 * MAX_HOLD; c++) begin
      bus.req = 4'b1111;
      who     = (c / MAX_HOLD) % 4;
      push_exp($sformatf("fair_c%0d", c), 4'b0001 << who, 2'(who), 1'b1,
               (c % MAX_HOLD == 0) && (c > 0));
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] reqs [5] = '{4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [7:0] want [5] = '{{4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b1000, 2'd3, 1'b1, 1'b0},
                             {4'b1000, 2'd3, 1'b1, 1'b0},
                             {4'b0000, 2'd3, 1'b0, 1'b0}};
    exp_t       e;
    logic [7:0] obs;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req = reqs[c];
      push_exp($sformatf("b2b_c%0d", c), want[c][7:4], want[c][3:2],
               want[c][1], want[c][0]);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
  endtask

  task automatic test_self_regrant();
    exp_t       e;
    logic [7:0] obs;
    apply_reset();
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      bus.req = 4'b1000;
      push_exp($sformatf("regrant_c%0d", c), 4'b1000, 2'd3, 1'b1,
               (c % MAX_HOLD == 0) && (c > 0));
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
  endtask

  task automatic test_coincide();
    // Client 0 drops in its last allowed cycle: hand-off to 1, no pulse.
    // Client 1 then drops in its last allowed cycle with nobody else: IDLE.
    logic [3:0] reqs [9] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010,
                             4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [7:0] want [9] = '{{4'b0001, 2'd0, 1'b1, 1'b0},
                             {4'b0001, 2'd0, 1'b1, 1'b0},
                             {4'b0001, 2'd0, 1'b1, 1'b0},
                             {4'b0001, 2'd0, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0000, 2'd1, 1'b0, 1'b0}};
    exp_t       e;
    logic [7:0] obs;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      bus.req = reqs[c];
      push_exp($sformatf("coincide_c%0d", c), want[c][7:4], want[c][3:2],
               want[c][1], want[c][0]);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic       rsts [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] want [5] = '{{4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0000, 2'd0, 1'b0, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0},
                             {4'b0010, 2'd1, 1'b1, 1'b0}};
    exp_t       e;
    logic [7:0] obs;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      bus.req = 4'b0010;
      rst     = rsts[c];
      push_exp($sformatf("midrst_c%0d", c), want[c][7:4], want[c][3:2],
               want[c][1], want[c][0]);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = observed();
      n_checks++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.v));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_self_regrant();
    test_coincide();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rr_arbiter_4

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares a single resource selected through a 2x4 decoder.
- A registered FSM picks one requester, then holds the grant until that requester releases or a hold timeout expires.
- The one-hot grant vector comes from an embedded decoder_2x4 instance driven by the granted index and a grant-active enable.
- Sits between four client blocks and the shared datapath or bus mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure. 0 disables the timeout. Must be less than 2**HOLD_W.
- HOLD_W, 8: width of the hold counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request lines; req[i]=1 means client i wants the resource. A client holds req high for its whole tenure.
- grant  out  4  one-hot grant from decoder_2x4; all zero when no grant is active.
- grant_idx  out  2  index of the current or last granted client.
- busy  out  1  high while in the GRANT state.
- timeout  out  1  one-cycle pulse when a tenure is cut off by MAX_HOLD.

Behaviour:
- Reset (rst sampled high): state=IDLE, cur_idx=0, last_idx=3, hold_cnt=0, timeout=0, so grant=0000, grant_idx=0, busy=0. The effect is visible from the next edge. Reset mid-tenure drops the grant regardless of req.
- Priority search: scan req starting at last_idx+1, mod 4, wrapping through all four indices. The first set bit wins. After reset, client 0 has top priority.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise go to GRANT with cur_idx=winner and hold_cnt=0.
  - Latency: req rising at edge N gives grant at edge N+1.
- GRANT, each cycle:
  - release = (req[cur_idx]==0).
  - expire = (MAX_HOLD!=0) and (hold_cnt==MAX_HOLD-1) and req[cur_idx].
  - No release and no expire: stay in GRANT, hold_cnt+1.
  - On release or expire: last_idx<=cur_idx, then search again from cur_idx+1.
  - If any req bit is set, move directly to the winner with hold_cnt=0 and no idle bubble. The state stays GRANT and grant switches in one edge.
  - If no req bit is set, go to IDLE and grant goes to 0000.
  - On expire, the current client is searched last. If it is the only requester it is re-granted, with hold_cnt reset.
- timeout: registered; equals 1 exactly in the cycle after expire, otherwise 0.
- Simultaneous events:
  - A requester dropping while others rise in the same cycle: the handoff uses the req value sampled that cycle.
  - Release and expire in the same cycle count as a release (no timeout pulse).
- Outputs:
  - grant = decoder_2x4(in=cur_idx, enable=busy). The decoder contract is an active-high enable and all-zero output when disabled.
  - grant_idx = cur_idx, which holds its value while in IDLE.
  - grant is glitch-free per cycle because it decodes registered state only.
- Arithmetic: hold_cnt is unsigned HOLD_W bits and never wraps, because it is cleared at MAX_HOLD-1. The index arithmetic is 2-bit mod-4.

Decomposition:
- Shared package / header: state encodings ST_IDLE=1'b0, ST_GRANT=1'b1, and N_REQ=4.
- Sub-module: reuse the existing decoder_2x4 (ports in, enable, out) for grant generation.
- The priority search is a local combinational function; no further sub-modules.

Test Plan:
1. Reset then single request: rst high 2 cycles, then req=0100 → next edge grant=0100, grant_idx=2, busy=1. Drop req → next edge grant=0000, busy=0, grant_idx stays 2.
2. Round-robin fairness: from reset, req=1111 held, MAX_HOLD=4 → grants rotate 0001,0010,0100,1000,0001…, each lasting 4 cycles with a timeout pulse after each, and no zero-grant cycle between them.
3. Back-to-back handoff: client 1 granted, req=1010. Client 1 drops req → next edge grant=1000 with busy staying 1 throughout.
4. Timeout self re-grant: only req[3]=1, MAX_HOLD=4 → grant=1000 continuous, timeout pulses every 4 cycles, grant_idx stays 3.
5. Release and expire coincide: req[cur] drops exactly on the MAX_HOLD-1 cycle → no timeout pulse; the next requester is granted or the FSM goes to IDLE.
6. Reset mid-tenure: grant=0010 with req=0010 still high, assert rst 1 cycle → grant=0000 next edge. After rst deasserts, client 1 is re-granted 1 cycle later (last_idx=3 so the search starts at 0, and 1 is the first set bit).
